// File: rtl/bignum_ctrl_pkg.sv
// bignum_ctrl_pkg: shared encodings for the big-number sequencer,
// its engines and the firmware header generator.
package bignum_ctrl_pkg;

   localparam int SEQ_W  = 7;
   localparam int WORD_W = 32;
   localparam int IDX_W  = 3;
   localparam int TMR_W  = 13;

   localparam int ST_ERR    = 2;
   localparam int ST_BUSY   = 1;
   localparam int ST_UNLOAD = 0;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_BUSY,
      S_UNLOAD,
      S_ERR
   } state_e;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_MUL  = 2'b01,
      OP_DIV  = 2'b10,
      OP_BAD  = 2'b11
   } op_e;

   function automatic logic [2:0] status_of(state_e s);
      logic [2:0] st;
      st            = '0;
      st[ST_ERR]    = (s == S_ERR);
      st[ST_BUSY]   = (s == S_BUSY);
      st[ST_UNLOAD] = (s == S_UNLOAD);
      return st;
   endfunction

endpackage

// File: rtl/bignum_seq_ctrl_if.sv
// bignum_seq_ctrl_if: shared operand/result bus between the
// sequencer (master) and the mul128/div64 engines (slave).
interface bignum_seq_ctrl_if;
   import bignum_ctrl_pkg::*;

   logic [WORD_W-1:0] eng_wdata;
   logic [IDX_W-1:0]  eng_widx;
   logic              mul_wvalid;
   logic              div_wvalid;
   logic              mul_start;
   logic              div_start;
   logic              mul_done;
   logic              div_done;
   logic [IDX_W-1:0]  eng_ridx;
   logic [WORD_W-1:0] mul_rdata;
   logic [WORD_W-1:0] div_rdata;

   modport master (
      output eng_wdata, eng_widx,
      output mul_wvalid, div_wvalid,
      output mul_start, div_start,
      output eng_ridx,
      input  mul_done, div_done,
      input  mul_rdata, div_rdata
   );

   modport slave (
      input  eng_wdata, eng_widx,
      input  mul_wvalid, div_wvalid,
      input  mul_start, div_start,
      input  eng_ridx,
      output mul_done, div_done,
      output mul_rdata, div_rdata
   );

endinterface

// File: rtl/gpio_seq_sync.sv
// gpio_seq_sync: 2-flop synchroniser for the MB sequence number
// plus a one-cycle stability detector to mask multi-bit skew.
module gpio_seq_sync
   import bignum_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [SEQ_W-1:0] seq_i,
   output logic [SEQ_W-1:0] seq_s_o,
   output logic             seq_stable_o
);

   logic [SEQ_W-1:0] meta_q;
   logic [SEQ_W-1:0] sync_q;
   logic [SEQ_W-1:0] prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '0;
         sync_q <= '0;
         prev_q <= '0;
      end else begin
         meta_q <= seq_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign seq_s_o      = sync_q;
   assign seq_stable_o = (sync_q == prev_q);

endmodule

// File: rtl/bignum_seq_ctrl.sv
// bignum_seq_ctrl: MicroBlaze GPIO mailbox sequencer for the
// mul128/div64 engines (command, operands, start, result unload).
module bignum_seq_ctrl
   import bignum_ctrl_pkg::*;
#(
   parameter int unsigned MUL_IN_WORDS  = 8,
   parameter int unsigned MUL_RES_WORDS = 8,
   parameter int unsigned DIV_IN_WORDS  = 4,
   parameter int unsigned DIV_RES_WORDS = 4,
   parameter int unsigned TIMEOUT_CYC   = 4096
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [WORD_W-1:0] mb_data_i,
   input  logic [SEQ_W-1:0]  mb_seq_i,
   output logic [SEQ_W-1:0]  ack_seq_o,
   output logic [WORD_W-1:0] rd_data_o,
   output logic [2:0]        status_o,
   bignum_seq_ctrl_if.master eng
);

   if (MUL_IN_WORDS < 1 || MUL_IN_WORDS > 8 ||
       MUL_RES_WORDS < 1 || MUL_RES_WORDS > 8 ||
       DIV_IN_WORDS < 1 || DIV_IN_WORDS > 8 ||
       DIV_RES_WORDS < 1 || DIV_RES_WORDS > 8 ||
       TIMEOUT_CYC < 1 || TIMEOUT_CYC > 8192) begin : g_bad_param
      $error("bignum_seq_ctrl: word counts 1..8, TIMEOUT_CYC 1..8192");
   end

   localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYC - 1);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [IDX_W-1:0]  widx_q, widx_d;
   logic [IDX_W-1:0]  ridx_q, ridx_d;
   logic [IDX_W-1:0]  eidx_q, eidx_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [SEQ_W-1:0]  ack_q, ack_d;
   logic [SEQ_W-1:0]  pseq_q, pseq_d;
   logic [1:0]        pend_q, pend_d;
   logic [WORD_W-1:0] rd_q, rd_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              mwv_q, mwv_d, dwv_q, dwv_d;
   logic              mst_q, mst_d, dst_q, dst_d;

   logic [SEQ_W-1:0]  seq_s;
   logic              seq_stable;
   logic              abort;
   logic              acc;
   logic              is_mul;
   logic              done_sel;
   logic [IDX_W-1:0]  in_last;
   logic [IDX_W-1:0]  res_last;
   logic [WORD_W-1:0] rdata_sel;

   gpio_seq_sync u_sync (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .seq_i        (mb_seq_i),
      .seq_s_o      (seq_s),
      .seq_stable_o (seq_stable)
   );

   // Accepts are blocked until the previous one has been acknowledged.
   assign abort     = (seq_s == '0);
   assign acc       = seq_stable && !abort && (seq_s != ack_q) &&
                      (pend_q == 2'b00);
   assign is_mul    = (op_q == OP_MUL);
   assign in_last   = is_mul ? IDX_W'(MUL_IN_WORDS - 1)
                             : IDX_W'(DIV_IN_WORDS - 1);
   assign res_last  = is_mul ? IDX_W'(MUL_RES_WORDS - 1)
                             : IDX_W'(DIV_RES_WORDS - 1);
   assign rdata_sel = is_mul ? eng.mul_rdata : eng.div_rdata;
   // While start is on the bus the engine still shows the previous done.
   assign done_sel  = (is_mul ? eng.mul_done : eng.div_done) &&
                      !(mst_q || dst_q);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      widx_d  = widx_q;
      ridx_d  = ridx_q;
      eidx_d  = eidx_q;
      tmr_d   = tmr_q;
      ack_d   = ack_q;
      pseq_d  = pseq_q;
      pend_d  = {pend_q[0], 1'b0};
      rd_d    = rd_q;
      wdata_d = wdata_q;
      mwv_d   = 1'b0;
      dwv_d   = 1'b0;
      mst_d   = 1'b0;
      dst_d   = 1'b0;

      if (pend_q[1]) ack_d = pseq_q;
      if (pend_q[0] && state_q == S_UNLOAD) rd_d = rdata_sel;

      unique case (state_q)
         S_IDLE: if (acc) begin
            pend_d = 2'b01;
            pseq_d = seq_s;
            widx_d = '0;
            unique case (1'b1)
               (mb_data_i[1:0] == OP_MUL): begin
                  op_d    = OP_MUL;
                  state_d = S_LOAD;
               end
               (mb_data_i[1:0] == OP_DIV): begin
                  op_d    = OP_DIV;
                  state_d = S_LOAD;
               end
               default: state_d = S_ERR;
            endcase
         end
         S_LOAD: if (acc) begin
            pend_d  = 2'b01;
            pseq_d  = seq_s;
            wdata_d = mb_data_i;
            eidx_d  = widx_q;
            mwv_d   = is_mul;
            dwv_d   = !is_mul;
            widx_d  = widx_q + 1'b1;
            if (widx_q == in_last) state_d = S_START;
         end
         S_START: begin
            if (acc) begin
               state_d = S_ERR;
            end else begin
               mst_d   = is_mul;
               dst_d   = !is_mul;
               tmr_d   = '0;
               ridx_d  = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (acc) begin
               state_d = S_ERR;
            end else if (done_sel) begin
               state_d = S_UNLOAD;
               rd_d    = rdata_sel;
            end else if (tmr_q == TMO_LAST) begin
               state_d = S_ERR;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_UNLOAD: if (acc) begin
            pend_d = 2'b01;
            pseq_d = seq_s;
            if (ridx_q == res_last) state_d = S_IDLE;
            else ridx_d = ridx_q + 1'b1;
         end
         S_ERR: ;
         default: state_d = S_IDLE;
      endcase

      if (abort) begin
         state_d = S_IDLE;
         ack_d   = '0;
         pend_d  = '0;
         widx_d  = '0;
         ridx_d  = '0;
         tmr_d   = '0;
         mwv_d   = 1'b0;
         dwv_d   = 1'b0;
         mst_d   = 1'b0;
         dst_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
         op_q    <= OP_MUL;
         widx_q  <= '0;
         ridx_q  <= '0;
         eidx_q  <= '0;
         tmr_q   <= '0;
         ack_q   <= '0;
         pseq_q  <= '0;
         pend_q  <= '0;
         rd_q    <= '0;
         wdata_q <= '0;
         mwv_q   <= 1'b0;
         dwv_q   <= 1'b0;
         mst_q   <= 1'b0;
         dst_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         widx_q  <= widx_d;
         ridx_q  <= ridx_d;
         eidx_q  <= eidx_d;
         tmr_q   <= tmr_d;
         ack_q   <= ack_d;
         pseq_q  <= pseq_d;
         pend_q  <= pend_d;
         rd_q    <= rd_d;
         wdata_q <= wdata_d;
         mwv_q   <= mwv_d;
         dwv_q   <= dwv_d;
         mst_q   <= mst_d;
         dst_q   <= dst_d;
      end
   end

   assign ack_seq_o      = ack_q;
   assign rd_data_o      = rd_q;
   assign status_o       = status_of(state_q);
   assign eng.eng_wdata  = wdata_q;
   assign eng.eng_widx   = eidx_q;
   assign eng.mul_wvalid = mwv_q;
   assign eng.div_wvalid = dwv_q;
   assign eng.mul_start  = mst_q;
   assign eng.div_start  = dst_q;
   assign eng.eng_ridx   = ridx_q;

endmodule

// File: tb/tb_bignum_seq_ctrl.sv
// tb_bignum_seq_ctrl: randomized mailbox transactions against
// behavioural mul/div engines and an arithmetic reference model.
module tb_bignum_seq_ctrl;
   import bignum_ctrl_pkg::*;

   localparam int TMO = 4096;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] mb_data = '0;
   logic [6:0]  mb_seq = '0;
   logic [6:0]  ack_seq;
   logic [31:0] rd_data;
   logic [2:0]  status;

   bignum_seq_ctrl_if eng ();

   bignum_seq_ctrl dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .mb_data_i (mb_data),
      .mb_seq_i  (mb_seq),
      .ack_seq_o (ack_seq),
      .rd_data_o (rd_data),
      .status_o  (status),
      .eng       (eng)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   logic [6:0] cur = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // behavioural engines: operands captured by index, result on start
   logic [31:0]  mop [8];
   logic [31:0]  dop [8];
   logic [255:0] mres = '0;
   logic [255:0] dres = '0;
   int mlat = 1, dlat = 1, msince = 0, dsince = 0;
   bit mrun = 1'b0, drun = 1'b0;
   logic [63:0] dn, dd;

   assign dn = {dop[1], dop[0]};
   assign dd = {dop[3], dop[2]};

   always @(posedge clk) begin
      if (eng.mul_wvalid) mop[eng.eng_widx] <= eng.eng_wdata;
      if (eng.div_wvalid) dop[eng.eng_widx] <= eng.eng_wdata;
      if (eng.mul_start) begin
         mres <= 256'({mop[3], mop[2], mop[1], mop[0]}) *
                 256'({mop[7], mop[6], mop[5], mop[4]});
         mrun <= 1'b1;
         msince <= 1;
      end else if (mrun) msince <= msince + 1;
      if (eng.div_start) begin
         dres <= (dd == 0) ? '0 : 256'({dn % dd, dn / dd});
         drun <= 1'b1;
         dsince <= 1;
      end else if (drun) dsince <= dsince + 1;
   end

   assign eng.mul_done  = mrun && mlat != 0 && msince >= mlat;
   assign eng.div_done  = drun && dlat != 0 && dsince >= dlat;
   assign eng.mul_rdata = mres[eng.eng_ridx*32 +: 32];
   assign eng.div_rdata = dres[eng.eng_ridx*32 +: 32];

   // strobe monitor
   logic [2:0]  mw_idx [$];
   logic [31:0] mw_dat [$];
   logic [2:0]  dw_idx [$];
   logic [31:0] dw_dat [$];
   int ms_n = 0, ds_n = 0, ms_cyc = 0;

   always @(negedge clk) begin
      if (eng.mul_wvalid) begin
         mw_idx.push_back(eng.eng_widx);
         mw_dat.push_back(eng.eng_wdata);
      end
      if (eng.div_wvalid) begin
         dw_idx.push_back(eng.eng_widx);
         dw_dat.push_back(eng.eng_wdata);
      end
      if (eng.mul_start) begin
         ms_n++;
         ms_cyc = cyc;
      end
      if (eng.div_start) ds_n++;
   end

   task automatic clear_mon();
      mw_idx.delete();
      mw_dat.delete();
      dw_idx.delete();
      dw_dat.delete();
      ms_n = 0;
      ds_n = 0;
   endtask

   function automatic void ref_model(input logic [1:0] op,
                                     input logic [31:0] w [8],
                                     output logic [31:0] r [8]);
      logic [127:0] a, b;
      logic [255:0] p;
      logic [63:0]  n, d, q, m;
      if (op == 2'b01) begin
         a = {w[3], w[2], w[1], w[0]};
         b = {w[7], w[6], w[5], w[4]};
         p = 256'(a) * 256'(b);
         for (int i = 0; i < 8; i++) r[i] = p[i*32 +: 32];
      end else begin
         n = {w[1], w[0]};
         d = {w[3], w[2]};
         q = n / d;
         m = n % d;
         r[0] = q[31:0];
         r[1] = q[63:32];
         r[2] = m[31:0];
         r[3] = m[63:32];
         for (int i = 4; i < 8; i++) r[i] = '0;
      end
   endfunction

   task automatic post(input logic [31:0] w);
      bit ok;
      @(negedge clk);
      mb_data = w;
      @(negedge clk);
      cur = (cur == 7'd127) ? 7'd1 : cur + 7'd1;
      mb_seq = cur;
      ok = 1'b0;
      for (int n = 0; n < 40 && !ok; n++) begin
         @(negedge clk);
         ok = (ack_seq === cur);
      end
      checks++;
      if (!ok) $display("FAIL ack_wait: ack_seq=%0d required=%0d", ack_seq, cur);
      else passes++;
   endtask

   task automatic abort_seq();
      @(negedge clk);
      mb_seq = '0;
      cur = '0;
      repeat (6) @(negedge clk);
   endtask

   task automatic rand_ops(input logic [1:0] op, output logic [31:0] w [8]);
      for (int i = 0; i < 8; i++) w[i] = $urandom;
      if (op == 2'b10 && $urandom_range(1, 0) == 1) begin
         w[3] = '0;
         w[2] = $urandom_range(1000, 1);
      end
      if (op == 2'b10 && {w[3], w[2]} == 64'd0) w[2] = 32'd7;
   endtask

   task automatic load_op(input logic [1:0] op, input logic [31:0] w [8]);
      post({30'($urandom), op});
      for (int i = 0; i < ((op == 2'b01) ? 8 : 4); i++) post(w[i]);
   endtask

   task automatic run_txn(input string name, input logic [1:0] op,
                          input logic [31:0] w [8], input int lat);
      logic [31:0] exp [8];
      int nin;
      bit ok, bad, m;
      m = (op == 2'b01);
      nin = m ? 8 : 4;
      ref_model(op, w, exp);
      mlat = lat;
      dlat = lat;
      clear_mon();
      load_op(op, w);
      ok = 1'b0;
      for (int n = 0; n < lat + 60 && !ok; n++) begin
         @(negedge clk);
         ok = (status === 3'b001);
      end
      checks++;
      if (!ok) $display("FAIL %s unload_wait: status=%b required=001", name, status);
      else passes++;
      bad = 1'b0;
      if (m) begin
         if (mw_idx.size() != nin || dw_idx.size() != 0 || ms_n != 1 || ds_n != 0) bad = 1'b1;
         else for (int i = 0; i < nin; i++)
            if (mw_idx[i] !== 3'(i) || mw_dat[i] !== w[i]) bad = 1'b1;
      end else begin
         if (dw_idx.size() != nin || mw_idx.size() != 0 || ds_n != 1 || ms_n != 0) bad = 1'b1;
         else for (int i = 0; i < nin; i++)
            if (dw_idx[i] !== 3'(i) || dw_dat[i] !== w[i]) bad = 1'b1;
      end
      checks++;
      if (bad) $display("FAIL %s strobes: mul_w=%0d div_w=%0d mul_start=%0d div_start=%0d required %0d writes idx 0.. and 1 start",
                        name, mw_idx.size(), dw_idx.size(), ms_n, ds_n, nin);
      else passes++;
      if (ok) begin
         checks++;
         if (rd_data !== exp[0]) $display("FAIL %s word0: rd_data=%h required=%h", name, rd_data, exp[0]);
         else passes++;
         for (int i = 1; i < nin; i++) begin
            post($urandom);
            checks++;
            if (rd_data !== exp[i]) $display("FAIL %s word%0d: rd_data=%h required=%h", name, i, rd_data, exp[i]);
            else passes++;
         end
         post($urandom);
         checks++;
         if (status !== 3'b000 || rd_data !== exp[nin-1])
            $display("FAIL %s to_idle: status=%b rd_data=%h required=000 %h", name, status, rd_data, exp[nin-1]);
         else passes++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if (ack_seq !== 7'd0 || rd_data !== 32'd0) $display("FAIL reset_mb: ack=%0d rd=%h required 0 0", ack_seq, rd_data);
      else passes++;
      checks++;
      if (status !== 3'b000) $display("FAIL reset_status: status=%b required=000", status);
      else passes++;
      checks++;
      if ({eng.mul_wvalid, eng.div_wvalid, eng.mul_start, eng.div_start} !== 4'd0)
         $display("FAIL reset_strobes: strobes=%b required=0000",
                  {eng.mul_wvalid, eng.div_wvalid, eng.mul_start, eng.div_start});
      else passes++;
      checks++;
      if (eng.eng_wdata !== 32'd0 || eng.eng_widx !== 3'd0 || eng.eng_ridx !== 3'd0)
         $display("FAIL reset_bus: wdata=%h widx=%0d ridx=%0d required 0", eng.eng_wdata, eng.eng_widx, eng.eng_ridx);
      else passes++;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_mul_basic();
      logic [31:0] w [8];
      for (int i = 0; i < 8; i++) w[i] = 32'(i + 1);
      run_txn("mul_basic", 2'b01, w, 5);
   endtask

   task automatic test_div();
      logic [31:0] w [8];
      for (int k = 0; k < 2; k++) begin
         rand_ops(2'b10, w);
         run_txn("div", 2'b10, w, $urandom_range(30, 1));
      end
   endtask

   task automatic test_bad_cmd();
      logic [31:0] cmds [3];
      cmds[0] = 32'h3;
      cmds[1] = 32'h0;
      cmds[2] = 32'hFFFF_FFFC;
      for (int k = 0; k < 3; k++) begin
         clear_mon();
         post(cmds[k]);
         repeat (10) @(negedge clk);
         checks++;
         if (status !== 3'b100) $display("FAIL bad_cmd_err: cmd=%h status=%b required=100", cmds[k], status);
         else passes++;
         checks++;
         if (mw_idx.size() + dw_idx.size() + ms_n + ds_n != 0)
            $display("FAIL bad_cmd_strobes: count=%0d required=0", mw_idx.size() + dw_idx.size() + ms_n + ds_n);
         else passes++;
         abort_seq();
         checks++;
         if (status !== 3'b000 || ack_seq !== 7'd0)
            $display("FAIL abort_err: status=%b ack=%0d required=000 0", status, ack_seq);
         else passes++;
      end
   endtask

   task automatic test_timeout();
      logic [31:0] w [8];
      bit ok;
      int err_cyc;
      rand_ops(2'b01, w);
      mlat = 0;
      clear_mon();
      load_op(2'b01, w);
      ok = 1'b0;
      err_cyc = 0;
      for (int n = 0; n < TMO + 200 && !ok; n++) begin
         @(negedge clk);
         if (status === 3'b100) begin
            ok = 1'b1;
            err_cyc = cyc;
         end
      end
      checks++;
      if (!ok || err_cyc - ms_cyc != TMO)
         $display("FAIL timeout_latency: seen=%0d cycles=%0d required=%0d", ok, err_cyc - ms_cyc, TMO);
      else passes++;
      abort_seq();
      rand_ops(2'b01, w);
      run_txn("done_at_timeout", 2'b01, w, TMO - 1);
   endtask

   task automatic test_abort_load();
      logic [31:0] w [8];
      post(32'h1);
      for (int i = 0; i < 3; i++) post($urandom);
      abort_seq();
      checks++;
      if (status !== 3'b000 || ack_seq !== 7'd0)
         $display("FAIL abort_load: status=%b ack=%0d required=000 0", status, ack_seq);
      else passes++;
      rand_ops(2'b01, w);
      run_txn("after_abort", 2'b01, w, $urandom_range(20, 1));
   endtask

   task automatic test_back_to_back();
      logic [31:0] w [8];
      logic [1:0] ops [5];
      ops[0] = 2'b01; ops[1] = 2'b01; ops[2] = 2'b10; ops[3] = 2'b10; ops[4] = 2'b01;
      for (int k = 0; k < 5; k++) begin
         rand_ops(ops[k], w);
         run_txn("b2b", ops[k], w, $urandom_range(30, 1));
      end
   endtask

   task automatic test_glitch_wrap();
      logic [31:0] w [8];
      logic [6:0] held;
      held = cur;
      @(negedge clk);
      mb_data = 32'h2;
      mb_seq = held + 7'd1;
      @(negedge clk);
      mb_seq = held;
      repeat (12) @(negedge clk);
      checks++;
      if (ack_seq !== held || status !== 3'b000)
         $display("FAIL glitch: ack=%0d status=%b required=%0d 000", ack_seq, status, held);
      else passes++;
      cur = 7'd118;
      rand_ops(2'b01, w);
      run_txn("wrap", 2'b01, w, $urandom_range(20, 1));
      checks++;
      if (ack_seq !== 7'd8) $display("FAIL wrap_ack: ack=%0d required=8", ack_seq);
      else passes++;
   endtask

   task automatic test_reset_unload();
      logic [31:0] w [8];
      bit ok;
      rand_ops(2'b10, w);
      dlat = 3;
      load_op(2'b10, w);
      ok = 1'b0;
      for (int n = 0; n < 60 && !ok; n++) begin
         @(negedge clk);
         ok = (status === 3'b001);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (!ok || {ack_seq, rd_data, status} !== '0 ||
          {eng.eng_wdata, eng.eng_widx, eng.eng_ridx} !== '0 ||
          {eng.mul_wvalid, eng.div_wvalid, eng.mul_start, eng.div_start} !== 4'd0)
         $display("FAIL async_reset: in_unload=%0d ack=%0d rd=%h status=%b ridx=%0d required all 0",
                  ok, ack_seq, rd_data, status, eng.eng_ridx);
      else passes++;
      mb_seq = '0;
      cur = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_div();
      test_bad_cmd();
      test_timeout();
      test_abort_load();
      test_back_to_back();
      test_glitch_wrap();
      test_reset_unload();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
